// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that time-shares one serial Mealy
// pattern detector among NCH requesters.
//
// Optional build macro: FIRST_HIT_ABORT_EN
//   defined   -> a frame ends on the first detector hit (hit_cnt = 1)
//   undefined -> every frame streams all W bits and counts every hit
//
// Handshake: req[i] is a level request that the channel holds until gnt[i]
// rises. gnt[i] rises combinationally in the IDLE cycle in which channel i
// wins arbitration; data for that channel is latched on that clock edge.
// gnt stays high for the whole frame and drops when the DONE cycle ends.
// done pulses for one cycle with done_ch/hit_cnt valid.
module seq_det_sched #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int HW  = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int BW = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] data,
    output logic [NCH-1:0]   gnt,
    output logic             det_clr,
    output logic             det_in,
    input  logic             det_out,
    output logic             done,
    output logic [CW-1:0]    done_ch,
    output logic [HW-1:0]    hit_cnt,
    output logic [1:0]       dbg_state
);

`ifdef FIRST_HIT_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   last;      // channel served most recently
    logic [CW-1:0]   cur;       // channel being served
    logic [CW-1:0]   pick;
    logic            pick_vld;
    logic [W-1:0]    sreg;      // latched word, shifted out MSB first
    logic [BW-1:0]   bit_idx;
    logic [HW-1:0]   cnt;

    // Round-robin pick: first requester after 'last', wrapping around.
    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            int idx;
            idx = int'(last) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (req[idx]) begin
                pick     = CW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and frame outputs.
    always_comb begin
        state_nx = state;
        gnt      = '0;
        det_clr  = 1'b0;
        det_in   = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                // Grant is gated by reset so nothing is offered while held in reset.
                if (pick_vld && rst) begin
                    gnt[pick] = 1'b1;
                    state_nx  = S_CLR;
                end
            end
            S_CLR: begin
                gnt[cur] = 1'b1;
                det_clr  = 1'b1;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                gnt[cur] = 1'b1;
                det_in   = sreg[W-1];
                if ((ABORT && det_out) || (bit_idx == BW'(W - 1)))
                    state_nx = S_DONE;
            end
            S_DONE: begin
                gnt[cur] = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: arbitration pointer, word latch/shift, bit index, hit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last    <= CW'(NCH - 1);
            cur     <= '0;
            sreg    <= '0;
            bit_idx <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        cur  <= pick;
                        last <= pick;
                        sreg <= data[int'(pick)*W +: W];
                    end
                end
                S_CLR: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                S_SHIFT: begin
                    sreg    <= {sreg[W-2:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                    if (det_out && (cnt != {HW{1'b1}}))
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done_ch   = cur;
    assign hit_cnt   = cnt;
    assign dbg_state = state;

endmodule
